// File: rtl/perturb_engine_n_if.sv
// Stream bundle for the GA mutation stage: crossover word in, child word plus
// mutation report out, with runtime reseed controls riding along the input side.
interface perturb_engine_n_if #(
  parameter int GENE_W    = 8,
  parameter int NUM_GENES = 4
);
  localparam int CNT_W = $clog2(NUM_GENES + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_GENES*GENE_W-1:0] crossover_gene;
  logic [7:0]                  perturb_prob;
  logic [1:0]                  mode;
  logic                        seed_load;
  logic [15:0]                 seed;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_GENES*GENE_W-1:0] child_gene;
  logic [NUM_GENES-1:0]        mutate_mask;
  logic [CNT_W-1:0]            mutate_count;

  modport master (
    output in_valid, crossover_gene, perturb_prob, mode, seed_load, seed, out_ready,
    input  in_ready, out_valid, child_gene, mutate_mask, mutate_count
  );

  modport slave (
    input  in_valid, crossover_gene, perturb_prob, mode, seed_load, seed, out_ready,
    output in_ready, out_valid, child_gene, mutate_mask, mutate_count
  );
endinterface

// File: rtl/perturb_engine_n.sv
// Per-field perturbation of a crossover gene word: each field owns a select
// and a value LFSR; one registered output stage with valid/ready flow control.

module perturb_lane #(
  parameter int          GENE_W    = 8,
  parameter int          IDX       = 0,
  parameter logic [15:0] SEED_BASE = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv_i,
  input  logic              load_i,
  input  logic [15:0]       seed_i,
  input  logic [7:0]        prob_i,
  input  logic [1:0]        mode_i,
  input  logic [GENE_W-1:0] field_i,
  output logic [GENE_W-1:0] field_o,
  output logic              hit_o
);
  localparam logic [15:0] SALT    = 16'(IDX * 32'h9E37);
  localparam logic [15:0] S0      = SEED_BASE ^ SALT;
  localparam logic [15:0] RST_SEL = (S0 == 16'h0000) ? 16'h0001 : S0;
  localparam logic [15:0] RST_VAL = (S0 == 16'hFFFF) ? 16'h0001 : ~S0;
  localparam logic [GENE_W-1:0] ONES = {GENE_W{1'b1}};

  logic [15:0]       sel_q, sel_d, val_q, val_d;
  logic [15:0]       ld_s;
  logic [GENE_W-1:0] r, r_nz, mut;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign ld_s = seed_i ^ SALT;

  always_comb begin
    sel_d = sel_q;
    val_d = val_q;
    // Reload wins; the top guarantees no accept in a reload cycle anyway.
    if (load_i) begin
      sel_d = (ld_s == 16'h0000) ? 16'h0001 : ld_s;
      val_d = (ld_s == 16'hFFFF) ? 16'h0001 : ~ld_s;
    end else if (adv_i) begin
      sel_d = lfsr_step(sel_q);
      val_d = lfsr_step(val_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= RST_SEL;
      val_q <= RST_VAL;
    end else begin
      sel_q <= sel_d;
      val_q <= val_d;
    end
  end

  assign r     = val_q[GENE_W-1:0];
  assign r_nz  = (r == '0) ? GENE_W'(1) : r;
  assign hit_o = (mode_i != 2'd3) && (sel_q[7:0] < prob_i);

  always_comb begin
    mut = field_i;
    unique case (mode_i)
      2'd0: mut = r;
      2'd1: mut = field_i ^ r_nz;
      2'd2: begin
        if (val_q[15]) mut = (field_i == ONES) ? field_i : field_i + GENE_W'(1);
        else           mut = (field_i == '0)   ? field_i : field_i - GENE_W'(1);
      end
      default: mut = field_i;
    endcase
  end

  assign field_o = hit_o ? mut : field_i;
endmodule

module perturb_engine_n #(
  parameter int          GENE_W    = 8,
  parameter int          NUM_GENES = 4,
  parameter logic [15:0] SEED_BASE = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  perturb_engine_n_if.slave    bus
);
  localparam int CNT_W = $clog2(NUM_GENES + 1);

  typedef struct packed {
    logic [NUM_GENES-1:0][GENE_W-1:0] child;
    logic [NUM_GENES-1:0]             mask;
    logic [CNT_W-1:0]                 count;
  } out_t;

  out_t                             out_q, out_d;
  logic                             out_valid_q, out_valid_d;
  logic                             in_ready, accept;
  logic [NUM_GENES-1:0][GENE_W-1:0] field_in, field_mut;
  logic [NUM_GENES-1:0]             hit;
  logic [CNT_W-1:0]                 cnt;

  assign field_in = bus.crossover_gene;
  assign in_ready = !bus.seed_load && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // LFSRs step only on accept so the child sequence depends on input order alone.
  for (genvar g = 0; g < NUM_GENES; g++) begin : g_lane
    perturb_lane #(
      .GENE_W    (GENE_W),
      .IDX       (g),
      .SEED_BASE (SEED_BASE)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .adv_i   (accept),
      .load_i  (bus.seed_load),
      .seed_i  (bus.seed),
      .prob_i  (bus.perturb_prob),
      .mode_i  (bus.mode),
      .field_i (field_in[g]),
      .field_o (field_mut[g]),
      .hit_o   (hit[g])
    );
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_GENES; i++) cnt = cnt + CNT_W'(hit[i]);
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_d.child = field_mut;
      out_d.mask  = hit;
      out_d.count = cnt;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.child_gene   = out_q.child;
  assign bus.mutate_mask  = out_q.mask;
  assign bus.mutate_count = out_q.count;
endmodule

// File: tb/tb_perturb_engine_n.sv
// Drives a 4x8 and an 8x4 instance with identical stimulus and checks both
// against a per-field arithmetic model of the mutation rules.
module tb_perturb_engine_n;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_iv, s_or, s_sl;
  logic [31:0] s_w;
  logic [7:0]  s_p;
  logic [1:0]  s_m;
  logic [15:0] s_sd;

  always #5 clk = ~clk;

  perturb_engine_n_if #(.GENE_W(8), .NUM_GENES(4)) ifa ();
  perturb_engine_n_if #(.GENE_W(4), .NUM_GENES(8)) ifb ();

  perturb_engine_n #(.GENE_W(8), .NUM_GENES(4), .SEED_BASE(16'hACE1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  perturb_engine_n #(.GENE_W(4), .NUM_GENES(8), .SEED_BASE(16'hACE1)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave));

  assign ifa.in_valid = s_iv;  assign ifb.in_valid = s_iv;
  assign ifa.crossover_gene = s_w;  assign ifb.crossover_gene = s_w;
  assign ifa.perturb_prob = s_p;  assign ifb.perturb_prob = s_p;
  assign ifa.mode = s_m;  assign ifb.mode = s_m;
  assign ifa.seed_load = s_sl;  assign ifb.seed_load = s_sl;
  assign ifa.seed = s_sd;  assign ifb.seed = s_sd;
  assign ifa.out_ready = s_or;  assign ifb.out_ready = s_or;

  logic        o_rdy [2];
  logic        o_val [2];
  logic [31:0] o_ch  [2];
  logic [7:0]  o_mk  [2];
  logic [3:0]  o_cn  [2];
  assign o_rdy[0] = ifa.in_ready;   assign o_rdy[1] = ifb.in_ready;
  assign o_val[0] = ifa.out_valid;  assign o_val[1] = ifb.out_valid;
  assign o_ch[0]  = ifa.child_gene; assign o_ch[1]  = ifb.child_gene;
  assign o_mk[0]  = {4'b0, ifa.mutate_mask};  assign o_mk[1] = ifb.mutate_mask;
  assign o_cn[0]  = {1'b0, ifa.mutate_count}; assign o_cn[1] = ifb.mutate_count;

  // Reference model state
  int unsigned sel_m [2][32];
  int unsigned val_m [2][32];
  int          ng [2];
  int          gw [2];
  bit          ev [2];
  int unsigned ec [2], em [2], en [2];

  int n_pass = 0, n_fail = 0;
  int sum_cnt, viol;
  int unsigned words [10];

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  function automatic int unsigned nz(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic int unsigned step(input int unsigned x);
    return (x % 2 == 1) ? ((x / 2) ^ 32'hB400) : (x / 2);
  endfunction

  task automatic m_seed(input int d, input int unsigned base);
    int unsigned s;
    for (int i = 0; i < ng[d]; i++) begin
      s = (base ^ (i * 32'h9E37)) & 32'hFFFF;
      sel_m[d][i] = nz(s);
      val_m[d][i] = nz(~s & 32'hFFFF);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_seed(d, 32'hACE1);
      ev[d] = 0; ec[d] = 0; em[d] = 0; en[d] = 0;
    end
  endtask

  task automatic m_beat(input int d, input int unsigned w, input int p, input int m);
    int unsigned mx, f, nf, r, child, mask, cnt;
    mx = (1 << gw[d]) - 1;
    child = 0; mask = 0; cnt = 0;
    for (int i = 0; i < ng[d]; i++) begin
      f  = (w >> (i * gw[d])) & mx;
      nf = f;
      if (m != 3 && (sel_m[d][i] % 256) < p) begin
        mask |= (1 << i);
        cnt++;
        r = val_m[d][i] & mx;
        case (m)
          0: nf = r;
          1: nf = f ^ ((r == 0) ? 1 : r);
          default: nf = (val_m[d][i] >= 32'h8000) ? ((f == mx) ? f : f + 1)
                                                  : ((f == 0) ? 0 : f - 1);
        endcase
      end
      child |= nf << (i * gw[d]);
      sel_m[d][i] = step(sel_m[d][i]);
      val_m[d][i] = step(val_m[d][i]);
    end
    ec[d] = child; em[d] = mask; en[d] = cnt;
  endtask

  // One clock of stimulus: drive, check in_ready, clock, update model, check outputs.
  task automatic cyc(input bit iv, input int unsigned w, input int p, input int m,
                     input bit orr, input bit sl, input int unsigned sd);
    bit er [2];
    bit acc [2];
    s_iv = iv; s_w = w; s_p = 8'(p); s_m = 2'(m); s_or = orr; s_sl = sl; s_sd = 16'(sd);
    #2;
    for (int d = 0; d < 2; d++) begin
      er[d]  = !sl && (!ev[d] || orr);
      acc[d] = iv && er[d];
      chk("in_ready", d, {31'b0, o_rdy[d]}, {31'b0, er[d]});
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (sl) m_seed(d, sd);
      if (acc[d]) begin
        m_beat(d, w, p, m);
        ev[d] = 1;
      end else if (ev[d] && orr) ev[d] = 0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("out_valid", d, {31'b0, o_val[d]}, {31'b0, ev[d]});
      if (ev[d]) begin
        chk("child_gene", d, o_ch[d], ec[d]);
        chk("mutate_mask", d, {24'b0, o_mk[d]}, em[d]);
        chk("mutate_count", d, {28'b0, o_cn[d]}, en[d]);
      end
    end
  endtask

  initial begin
    ng[0] = 4; gw[0] = 8; ng[1] = 8; gw[1] = 4;
    rst = 1'b0;
    s_iv = 1'b1; s_w = 32'h12345678; s_p = 8'd255; s_m = 2'd0;
    s_or = 1'b1; s_sl = 1'b0; s_sd = 16'h0;
    m_reset();

    // Reset held with in_valid high: everything stays zero
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, {31'b0, o_val[d]}, 32'h0);
      chk("rst_child", d, o_ch[d], 32'h0);
      chk("rst_mask", d, {24'b0, o_mk[d]}, 32'h0);
      chk("rst_count", d, {28'b0, o_cn[d]}, 32'h0);
    end
    #2 rst = 1'b1;

    // prob 0 never mutates
    for (int k = 0; k < 16; k++) cyc(1, 32'hDEADBEEF, 0, 0, 1, 0, 0);
    chk("prob0_child", 0, o_ch[0], 32'hDEADBEEF);
    chk("prob0_mask", 0, {24'b0, o_mk[0]}, 32'h0);

    // prob 255 bit-flip on zero words: mutated fields must be nonzero
    sum_cnt = 0; viol = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc(1, 32'h0, 255, 1, 1, 0, 0);
      sum_cnt += o_cn[0];
      for (int i = 0; i < 4; i++)
        if ((o_ch[0][i*8 +: 8] != 8'h0) != o_mk[0][i]) viol++;
    end
    chk("flip_zero_rule", 0, viol, 0);
    chk("flip_avg_count", 0, {31'b0, (sum_cnt >= 3930 && sum_cnt <= 4030)}, 32'h1);

    // Step mode with saturating edges
    for (int k = 0; k < 8; k++) cyc(1, 32'hFF00FF00, 255, 2, 1, 0, 0);

    // Bypass mode: LFSRs advance, mask stays zero
    for (int k = 0; k < 4; k++) cyc(1, $urandom, 255, 3, 1, 0, 0);

    // Backpressure: output held and LFSRs frozen during the stall
    cyc(1, 32'hA5A55A5A, 128, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 32'h11111111 * k, 200, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 32'h0F0F0F0F + k, 200, 1, 1, 0, 0);

    // Reseed together with in_valid: no accept that cycle, then two identical runs
    for (int k = 0; k < 10; k++) words[k] = $urandom;
    for (int run = 0; run < 2; run++) begin
      cyc(1, 32'hCAFEF00D, 255, 0, 1, 1, 32'h1234);
      for (int k = 0; k < 10; k++) cyc(1, words[k], 180, k % 3, 1, 0, 0);
    end

    // Randomized traffic with stalls and occasional reseeds
    for (int k = 0; k < 400; k++)
      cyc(($urandom % 4) != 0, $urandom, $urandom % 256, $urandom % 4,
          ($urandom % 4) != 0, ($urandom % 40) == 0, $urandom % 65536);

    // Reset mid-transfer: pending output dropped at once, LFSRs restart
    cyc(1, 32'h76543210, 255, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_valid", d, {31'b0, o_val[d]}, 32'h0);
      chk("async_rst_child", d, o_ch[d], 32'h0);
    end
    m_reset();
    #1 rst = 1'b1;
    for (int k = 0; k < 12; k++) cyc(1, $urandom, $urandom % 256, $urandom % 3, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
